muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Takes the same rs1/rs2 operands as the ALU, with an MDOp code from the decoder.
- Returns a 32-bit result after a fixed multi-cycle latency.
- Drives busy/done so the hazard unit can stall IF/ID/EX and flush can abort a speculative operation.

Parameters:
- WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
- clk    input  1      rising-edge clock
- rstn   input  1      synchronous active-low reset
- start  input  1      EX holds a valid M-extension instruction; sampled only in IDLE
- MDOp   input  3      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- A      input  WIDTH  rs1 operand (forwarded value)
- B      input  WIDTH  rs2 operand (forwarded value)
- flush  input  1      branch/jump flush of EX; aborts the operation in flight
- busy   output 1      operation in progress; registered
- done   output 1      one-cycle pulse; C valid
- C      output WIDTH  result; held until the next accepted start

Behaviour:
- Reset: rstn low at a clock edge puts state in IDLE and clears busy, done, C and all internal registers, including mid-operation. Reset has priority over every other input.
- States: IDLE, RUN, FIX. done is a registered pulse issued when leaving FIX or on a fast path.
- Acceptance: IDLE, start=1, flush=0 at edge E0:
  - latch MDOp, the operand signs and the magnitudes |A|, |B|; unsigned ops and the unsigned side of MULHSU use raw values;
  - set count=0, busy=1, state=RUN.
- Fast path, division only, decided at E0: state stays IDLE; at E0 C gets the result and done=1 for one cycle; busy stays 0.
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- RUN: one radix-2 iteration per edge, count increments, 32 iterations on E1..E32.
  - Multiply: shift-add into a 64-bit product register.
  - Divide: restoring shift-subtract, 32-bit quotient and remainder.
  - After the iteration at E32, state goes to FIX.
- FIX, edge E33:
  - apply sign correction; product negated if signs differ;
  - quotient negated if the signs of A and B differ; remainder takes the sign of A;
  - select the low product word (MUL), high word (MULH/MULHSU/MULHU), quotient or remainder;
  - C is loaded, done=1, busy=0, state=IDLE.
- Latency: done is high in the cycle after E33 (33 cycles after the accepting edge).
  - start may be accepted at the edge ending the done cycle (back-to-back).
  - The hazard unit stalls on (start | busy) & ~done.
- start while busy is ignored; operands and MDOp are not re-sampled.
- flush: in RUN or FIX, the next edge gives state=IDLE, busy=0, done=0, C unchanged. flush and start in the same IDLE cycle: flush wins, nothing accepted.
- done is never asserted for an aborted operation.
- Width rules:
  - MULHSU: A signed, B unsigned.
  - Results are two's complement modulo 2^32, except the high-word selects from the 64-bit product.

Decomposition:
- MDOp encodings go in ctrl_encode_def.v as `MDOp_mul .. `MDOp_remu defines, alongside the ALUOp defines. State encodings stay local.
- No sub-module is required. The shared 33-bit adder/subtractor may optionally be a leaf muldiv_addsub; it is not mandated.

Test Plan:
- MUL A=7, B=0xFFFFFFFD: busy high cycles 1..33, done exactly 33 cycles after start, C=0xFFFFFFEB.
- A=B=0xFFFFFFFF: MULHU gives 0xFFFFFFFE, MULH gives 0x00000000, MULHSU gives 0xFFFFFFFF, MUL gives 0x00000001.
- DIV 0xFFFFFFF9/2 gives 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU 100/7 gives 14; REMU 100/7 gives 2; back-to-back starts each complete in 33 cycles.
- DIV 5/0 gives 0xFFFFFFFF; REMU 5/0 gives 5; DIV 0x80000000/0xFFFFFFFF gives 0x80000000; REM of the same gives 0. Each gives done one cycle after start with busy never high.
- flush at cycle 10 of a DIVU: busy low next cycle, no done, C keeps its prior value. start pulses while busy do not alter the result. A later start completes normally.
- rstn low at cycle 5 of a MUL: at the next edge busy=0, done=0, C=0. start during rstn low is ignored.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// the MDOp encoding and the per-operation signedness helpers.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  function automatic logic op_is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  // Quotient-producing division ops (as opposed to remainder ops).
  function automatic logic op_is_quot(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic op_a_signed(input md_op_e op);
    return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // MULHSU treats rs2 as unsigned, so it is absent here.
  function automatic logic op_b_signed(input md_op_e op);
    return op inside {MD_MULH, MD_DIV, MD_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit: magnitudes are processed for WIDTH
// cycles in one 2*WIDTH accumulator, then sign-corrected in a final FIX cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state, state_next;
  md_op_e             op;
  logic               neg_a, neg_b;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;

  md_op_e             op_in;
  logic               sa_in, sb_in;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               div_zero, div_ovf, fast;
  logic [WIDTH-1:0]   fast_result;
  logic               accept, fast_hit;

  // Operand decode at acceptance time.
  assign op_in    = md_op_e'(MDOp);
  assign sa_in    = op_a_signed(op_in) & A[WIDTH-1];
  assign sb_in    = op_b_signed(op_in) & B[WIDTH-1];
  assign mag_a    = sa_in ? -A : A;
  assign mag_b    = sb_in ? -B : B;
  assign div_zero = (B == '0);
  assign div_ovf  = (op_in inside {MD_DIV, MD_REM}) &&
                    (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
  assign fast     = op_is_div(op_in) && (div_zero || div_ovf);

  always_comb begin
    if (div_zero) fast_result = op_is_quot(op_in) ? '1 : A;
    else          fast_result = op_is_quot(op_in) ? A  : '0;
  end

  // One multiply step: conditional add of the multiplicand, then shift right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // One restoring divide step on {remainder, quotient}.
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_diff;
  logic [2*WIDTH-1:0] div_next;
  assign rem_sh   = acc[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = (rem_sh >= {1'b0, opb});
  assign rem_diff = rem_sh[WIDTH-1:0] - opb;
  assign div_next = rem_ge ? {rem_diff, acc[WIDTH-2:0], 1'b1}
                           : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  // Sign correction and result select for the FIX cycle.
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s, fix_result;
  assign prod_s = (neg_a ^ neg_b) ? -acc : acc;
  assign quo_s  = (neg_a ^ neg_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_s  = neg_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    unique case (op)
      MD_MUL:                    fix_result = prod_s[WIDTH-1:0];
      MD_MULH, MD_MULHSU,
      MD_MULHU:                  fix_result = prod_s[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:           fix_result = quo_s;
      default:                   fix_result = rem_s;
    endcase
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    fast_hit   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !flush) begin
          if (fast) fast_hit = 1'b1;
          else begin
            accept     = 1'b1;
            state_next = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (flush)                            state_next = S_IDLE;
        else if (count == CW'(WIDTH - 1))     state_next = S_FIX;
      end
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order. All registers,
  // datapath included, are cleared by reset so an aborted operation leaves
  // no residue.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      C     <= '0;
      op    <= MD_MUL;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      count <= '0;
      acc   <= '0;
      opb   <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      done  <= fast_hit || (state == S_FIX && !flush);

      if (accept) begin
        op    <= op_in;
        neg_a <= sa_in;
        neg_b <= sb_in;
        count <= '0;
        // Divide: {0, dividend}, divisor in opb. Multiply: {0, multiplier},
        // multiplicand in opb.
        acc   <= op_is_div(op_in) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        opb   <= op_is_div(op_in) ? mag_b : mag_a;
      end else if (state == S_RUN && !flush) begin
        acc   <= op_is_div(op) ? div_next : mul_next;
        count <= count + 1'b1;
      end

      if (fast_hit)                     C <= fast_result;
      else if (state == S_FIX && !flush) C <= fix_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a stimulus process pushes reference
// results, a monitor pops and compares them on every done pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rstn, start, flush;
  logic [2:0]  MDOp;
  logic [31:0] A, B, C;
  logic        busy, done;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_c;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .MDOp(MDOp), .A(A), .B(B),
    .flush(flush), .busy(busy), .done(done), .C(C)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // RV32M semantics computed with plain 64-bit / 32-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'd0: begin p = ua * ub;             return p[31:0];  end
      3'd1: begin p = sa * sb;             return p[63:32]; end
      3'd2: begin p = sa * longint'(ub);   return p[63:32]; end
      3'd3: begin p = ua * ub;             return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  always @(negedge clk) begin
    if (rstn && done) begin
      if (exp_q.size() == 0) check("unexpected_done", C, 32'hxxxx_xxxx);
      else check("result", C, exp_q.pop_front());
    end
  end

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    int          k;
    bit          fast, busy_ok;
    logic [31:0] exp;
    fast = is_fast(op, a, b);
    exp  = ref_model(op, a, b);
    exp_q.push_back(exp);
    drive(op, a, b);
    @(posedge clk);
    @(negedge clk);
    k       = 0;
    busy_ok = 1'b1;
    forever begin
      if (busy !== ((!fast) && k < 33)) busy_ok = 1'b0;
      if (done || k >= 100) break;
      start = noise && (k == 4 || k == 11);
      if (start) begin
        MDOp = 3'($urandom);
        A    = $urandom;
        B    = $urandom;
      end
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    start  = 1'b0;
    last_c = exp;
    check($sformatf("latency_op%0d", op), k, fast ? 32'd0 : 32'd33);
    check($sformatf("busy_profile_op%0d", op), {31'd0, busy_ok}, 32'd1);
  endtask

  task automatic cycle;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    bit          saw_done;
    logic [2:0]  op;
    logic [31:0] a, b;

    rstn = 1'b0; start = 1'b0; flush = 1'b0; MDOp = '0; A = '0; B = '0;
    @(negedge clk);
    cycle();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_c", C, 32'd0);
    rstn = 1'b1;
    cycle();

    // Directed: multiply high/low words and signed division corner cases.
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(3'd5, 32'd100, 32'd7, 1'b0);
    run_op(3'd7, 32'd100, 32'd7, 1'b0);
    run_op(3'd4, 32'd5, 32'd0, 1'b0);
    run_op(3'd7, 32'd5, 32'd0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(3'd6, 32'd7, 32'hFFFF_FFFE, 1'b1);

    // Flush mid-DIVU: abort, no done, C keeps the previous result.
    drive(3'd5, $urandom, $urandom | 32'd1);
    cycle();
    start = 1'b0;
    repeat (9) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_c_held", C, last_c);
    saw_done = 1'b0;
    repeat (40) begin
      cycle();
      saw_done |= done;
    end
    check("flush_no_done", {31'd0, saw_done}, 32'd0);

    // flush wins over start in the same idle cycle.
    drive(3'd0, 32'd3, 32'd4);
    flush = 1'b1;
    cycle();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", {31'd0, busy}, 32'd0);
    cycle();
    check("flush_start_done", {31'd0, done}, 32'd0);
    run_op(3'd5, 32'd1000, 32'd33, 1'b0);

    // Reset mid-MUL; start while in reset is ignored.
    drive(3'd0, 32'd12345, 32'd678);
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    rstn = 1'b0;
    drive(3'd0, 32'd3, 32'd5);
    cycle();
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_c", C, 32'd0);
    cycle();
    rstn  = 1'b1;
    start = 1'b0;
    cycle();
    check("rst_start_ignored", {30'd0, busy, done}, 32'd0);
    last_c = 32'd0;
    run_op(3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0);

    // Random back-to-back stream with occasional corner operands.
    for (int i = 0; i < 30; i++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(1, 15);
        default: ;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0));
    end

    cycle();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
